// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop based up/down counter.
package tff_pkg;

    // Two-bit operating mode of the counter.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'b00;
    localparam mode_t MODE_UP     = 2'b01;
    localparam mode_t MODE_DOWN   = 2'b10;
    localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/tff_updown_counter_if.sv
// Control and status bundle between a counter user (master) and the counter (slave).
interface tff_updown_counter_if #(
    parameter int WIDTH = 4
) ();
    import tff_pkg::*;

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] t_in;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, t_in, load, load_val,
        input  q, q_bar, tc, wrap
    );

    modport slave (
        input  en, mode, t_in, load, load_val,
        output q, q_bar, tc, wrap
    );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on a rising edge when t is high.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q,
    output logic q_bar
);

    // State bit: cleared asynchronously, inverted whenever t is sampled high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

    assign q_bar = ~q;

endmodule

// File: rtl/tff_updown_counter.sv
// WIDTH-bit counter built from T cells: raw toggle, modulo up/down count,
// hold, synchronous load, terminal-count flag and a registered wrap pulse.
module tff_updown_counter
    import tff_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    tff_updown_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_bar_r;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t_vec;
    logic             next_wrap;
    logic             wrap_r;

    // Next-state selection: load wins, then an enabled non-hold mode, else hold.
    always_comb begin
        next_q    = q_r;
        next_wrap = 1'b0;
        if (bus.load) begin
            next_q = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_TOGGLE: next_q = q_r ^ bus.t_in;
                MODE_UP: begin
                    // Values above MAX_Q (reachable through TOGGLE) also wrap.
                    if (q_r >= MAX_Q) begin
                        next_q    = SATURATE ? MAX_Q : '0;
                        next_wrap = 1'b1;
                    end else begin
                        next_q = q_r + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    // Values above MAX_Q simply decrement without flagging.
                    if (q_r == '0) begin
                        next_q    = SATURATE ? '0 : MAX_Q;
                        next_wrap = 1'b1;
                    end else begin
                        next_q = q_r - WIDTH'(1);
                    end
                end
                default: next_q = q_r;
            endcase
        end
    end

    // Every state change, load included, is expressed as a per-bit toggle.
    assign t_vec = q_r ^ next_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (t_vec[i]),
                .q     (q_r[i]),
                .q_bar (q_bar_r[i])
            );
        end
    endgenerate

    // Wrap/saturation pulse, one cycle behind the event that caused it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wrap_r <= 1'b0;
        else
            wrap_r <= next_wrap;
    end

    assign bus.q     = q_r;
    assign bus.q_bar = q_bar_r;
    assign bus.wrap  = wrap_r;
    assign bus.tc    = bus.en & ~bus.load &
                       (((bus.mode == MODE_UP)   & (q_r >= MAX_Q)) |
                        ((bus.mode == MODE_DOWN) & (q_r == '0)));

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench: two counters (MAX_VAL=9, wrapping and saturating) driven in
// sequence; expected outputs are queued with each stimulus and checked after it.
module tb_tff_updown_counter;
    import tff_pkg::*;

    logic clk;
    logic reset;

    tff_updown_counter_if #(.WIDTH(4)) ifa ();
    tff_updown_counter_if #(.WIDTH(4)) ifs ();

    tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    tff_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input bit sel, input logic [3:0] q,
                        input logic tc, input logic wrap);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.q    = q;
        e.tc   = tc;
        e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic exp_a(input string tag, input logic [3:0] q, input logic tc, input logic wrap);
        push(tag, 1'b0, q, tc, wrap);
    endtask

    task automatic exp_s(input string tag, input logic [3:0] q, input logic tc, input logic wrap);
        push(tag, 1'b1, q, tc, wrap);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [9:0] obs;
        logic [9:0] want;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            obs  = e.sel ? {ifs.q, ifs.q_bar, ifs.tc, ifs.wrap}
                         : {ifa.q, ifa.q_bar, ifa.tc, ifa.wrap};
            want = {e.q, ~e.q, e.tc, e.wrap};
            checks++;
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s: got q=%h q_bar=%h tc=%b wrap=%b, expected q=%h q_bar=%h tc=%b wrap=%b",
                       e.tag, obs[9:6], obs[5:2], obs[1], obs[0],
                       want[9:6], want[5:2], want[1], want[0]);
            end
        end
    endtask

    // Advance one rising edge and check queued expectations just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Check queued expectations without a clock edge (combinational / async).
    task automatic probe();
        #1;
        check_all();
    endtask

    initial begin
        reset        = 1'b0;
        ifa.en       = 1'b1;
        ifa.mode     = MODE_UP;
        ifa.t_in     = 4'h0;
        ifa.load     = 1'b0;
        ifa.load_val = 4'h0;
        ifs.en       = 1'b0;
        ifs.mode     = MODE_HOLD;
        ifs.t_in     = 4'h0;
        ifs.load     = 1'b0;
        ifs.load_val = 4'h0;

        // Reset held through three edges with UP enabled
        repeat (3) begin
            exp_a("rst_hold", 4'h0, 1'b0, 1'b0);
            tick();
        end
        exp_s("rst_sat", 4'h0, 1'b0, 1'b0);
        probe();

        // Release: count from zero
        reset = 1'b1;
        exp_a("rel_1", 4'h1, 1'b0, 1'b0); tick();
        exp_a("rel_2", 4'h2, 1'b0, 1'b0); tick();
        exp_a("rel_3", 4'h3, 1'b0, 1'b0); tick();

        // UP wrap at MAX_VAL=9
        ifa.load = 1'b1; ifa.load_val = 4'h8;
        exp_a("up_load8", 4'h8, 1'b0, 1'b0); tick();
        ifa.load = 1'b0;
        exp_a("up_to_max", 4'h9, 1'b1, 1'b0); tick();
        exp_a("up_wrap", 4'h0, 1'b0, 1'b1); tick();
        exp_a("up_after_wrap", 4'h1, 1'b0, 1'b0); tick();

        // Load priority at the bound: clamp 15->9, suppresses wrap and tc
        ifa.load = 1'b1; ifa.load_val = 4'h9;
        exp_a("load9", 4'h9, 1'b0, 1'b0); tick();
        ifa.load_val = 4'hF;
        exp_a("prio_pre_tc", 4'h9, 1'b0, 1'b0); probe();
        exp_a("prio_clamp", 4'h9, 1'b0, 1'b0); tick();
        ifa.load = 1'b0;
        exp_a("prio_tc_after", 4'h9, 1'b1, 1'b0); probe();
        exp_a("wrap_after_prio", 4'h0, 1'b0, 1'b1); tick();

        // TOGGLE, including values above MAX_VAL
        ifa.mode = MODE_TOGGLE; ifa.t_in = 4'b1010;
        exp_a("toggle_1", 4'hA, 1'b0, 1'b0); tick();
        exp_a("toggle_2", 4'h0, 1'b0, 1'b0); tick();
        ifa.t_in = 4'b1100;
        exp_a("toggle_above", 4'hC, 1'b0, 1'b0); tick();
        ifa.mode = MODE_DOWN;
        exp_a("down_above_max", 4'hB, 1'b0, 1'b0); tick();
        ifa.mode = MODE_UP;
        exp_a("tc_above_max", 4'hB, 1'b1, 1'b0); probe();
        exp_a("up_above_max", 4'h0, 1'b0, 1'b1); tick();

        // HOLD and en=0
        ifa.mode = MODE_HOLD;
        exp_a("hold", 4'h0, 1'b0, 1'b0); tick();
        ifa.mode = MODE_DOWN; ifa.en = 1'b0;
        exp_a("en_off", 4'h0, 1'b0, 1'b0); tick();

        // DOWN wrap from 0
        ifa.en = 1'b1;
        exp_a("down_tc", 4'h0, 1'b1, 1'b0); probe();
        exp_a("down_wrap", 4'h9, 1'b0, 1'b1); tick();

        // Load acts with en=0
        ifa.en = 1'b0; ifa.load = 1'b1; ifa.load_val = 4'h5;
        exp_a("load_en0", 4'h5, 1'b0, 1'b0); tick();

        // Asynchronous reset off the clock edge at q=5
        ifa.load = 1'b0; ifa.en = 1'b1; ifa.mode = MODE_UP;
        #3;
        reset = 1'b0;
        exp_a("async_rst", 4'h0, 1'b0, 1'b0); probe();
        exp_a("rst_held_edge", 4'h0, 1'b0, 1'b0); tick();
        reset = 1'b1;
        exp_a("resume_1", 4'h1, 1'b0, 1'b0); tick();
        exp_a("resume_2", 4'h2, 1'b0, 1'b0); tick();

        // Saturating counter: DOWN stays at 0, UP stays at 9, wrap pulses
        ifa.en = 1'b0;
        ifs.load = 1'b1; ifs.load_val = 4'h1;
        exp_s("sat_load1", 4'h1, 1'b0, 1'b0); tick();
        ifs.load = 1'b0; ifs.mode = MODE_DOWN; ifs.en = 1'b1;
        exp_s("sat_down_1", 4'h0, 1'b1, 1'b0); tick();
        exp_s("sat_down_2", 4'h0, 1'b1, 1'b1); tick();
        exp_s("sat_down_3", 4'h0, 1'b1, 1'b1); tick();
        ifs.mode = MODE_UP; ifs.load = 1'b1; ifs.load_val = 4'hC;
        exp_s("sat_load_clamp", 4'h9, 1'b0, 1'b0); tick();
        ifs.load = 1'b0;
        exp_s("sat_up", 4'h9, 1'b1, 1'b1); tick();
        ifs.en = 1'b0;
        exp_s("sat_idle", 4'h9, 1'b0, 1'b0); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
